// File: rtl/uart_pkg.sv
// uart_pkg -- shared types and constants for the UART receive path.
//   uart_rx_state_t   : receiver FSM state encoding
//   MIN_CLKS_PER_BIT  : lowest oversampling ratio the receiver accepts
//   clks_per_bit()    : system clocks per bit time (integer floor)
package uart_pkg;

   localparam int MIN_CLKS_PER_BIT = 4;

   // PARITY is only entered when UART_RX_PARITY_EN is defined.
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } uart_rx_state_t;

   function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
      return clk_freq / baud_rate;
   endfunction

endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if -- write port from the UART receiver into the RX FIFO.
//   WEo   : one-cycle write strobe (receiver -> FIFO)
//   WDo   : received byte, valid while WEo = 1 (receiver -> FIFO)
//   FULLi : FIFO full flag (FIFO -> receiver)
// Modports: master = receiver side, slave = FIFO side.
interface uart_rx_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  WEo;
   logic [DATA_WIDTH-1:0] WDo;
   logic                  FULLi;

   modport master (output WEo, output WDo, input FULLi);
   modport slave  (input WEo, input WDo, output FULLi);
endinterface

// File: rtl/uart_sync2.sv
// uart_sync2 -- two-flop synchronizer for a single asynchronous input.
//   clk : destination clock, rising edge
//   rst : asynchronous, active-high reset; both flops reset to 1
//   d   : asynchronous input
//   q   : synchronized output
// Resetting to 1 matches an idle-high serial line, so no false edge is
// seen when reset is released.
module uart_sync2 (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta_p0;
   logic sync_p1;

   // stage 0: metastability capture / stage 1: settled copy
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_p0 <= 1'b1;
         sync_p1 <= 1'b1;
      end else begin
         meta_p0 <= d;
         sync_p1 <= meta_p0;
      end
   end

   assign q = sync_p1;

endmodule

// File: rtl/uart_rx.sv
// uart_rx -- oversampling UART receiver feeding an RX FIFO.
// Ports:
//   CLKip : system clock, rising edge
//   RSTi  : asynchronous, active-high reset
//   RXi   : serial line, asynchronous, idles high
//   fifo  : uart_rx_if.master -- WEo/WDo write strobe and byte, FULLi flag
//   BUSYo : frame in progress
//   FEo   : one-cycle framing-error pulse (stop bit sampled low)
//   PEo   : one-cycle parity-error pulse
//   OVRo  : one-cycle overrun pulse (good byte dropped, FIFO full)
// Build option: define UART_RX_PARITY_EN to add a parity bit between the
// data bits and the stop bit (even or odd per PARITY_ODD). Without it PEo
// is tied low and PARITY_ODD has no effect.
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int BAUD_RATE  = 115_200,
   parameter int DATA_WIDTH = 8,
   parameter int PARITY_ODD = 0
) (
   input  logic          CLKip,
   input  logic          RSTi,
   input  logic          RXi,
   uart_rx_if.master     fifo,
   output logic          BUSYo,
   output logic          FEo,
   output logic          PEo,
   output logic          OVRo
);

   localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
   localparam int HALF_BIT     = CLKS_PER_BIT / 2;
   localparam int CNT_W        = $clog2(CLKS_PER_BIT);
   localparam int BIT_W        = $clog2(DATA_WIDTH);

   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

   if (CLKS_PER_BIT < MIN_CLKS_PER_BIT) begin : g_bad_rate
      $error("uart_rx: CLK_FREQ/BAUD_RATE must be at least %0d", MIN_CLKS_PER_BIT);
   end
   if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_bad_width
      $error("uart_rx: DATA_WIDTH must be 5..9");
   end
   if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity
      $error("uart_rx: PARITY_ODD must be 0 or 1");
   end

   logic rx_sync;
   logic rx_prev;
   logic rx_fall;

   uart_rx_state_t        state, state_nxt;
   logic [CNT_W-1:0]      cnt, cnt_nxt;
   logic [BIT_W-1:0]      bit_idx, bit_nxt;
   logic [DATA_WIDTH-1:0] shreg, shreg_nxt;
   logic [DATA_WIDTH-1:0] wd, wd_nxt;
   logic                  we, we_nxt;
   logic                  fe, fe_nxt;
   logic                  ovr, ovr_nxt;
   logic                  cnt_zero;
`ifdef UART_RX_PARITY_EN
   logic                  par_err, par_err_nxt;
   logic                  pe, pe_nxt;
`endif

   // stage 0/1: line synchronizer; stage 2: delayed copy for edge detect
   uart_sync2 u_sync (
      .clk (CLKip),
      .rst (RSTi),
      .d   (RXi),
      .q   (rx_sync)
   );

   always_ff @(posedge CLKip or posedge RSTi) begin
      if (RSTi) rx_prev <= 1'b1;
      else      rx_prev <= rx_sync;
   end

   assign rx_fall  = rx_prev & ~rx_sync;
   assign cnt_zero = (cnt == '0);

   // FSM state and result registers
   always_ff @(posedge CLKip or posedge RSTi) begin
      if (RSTi) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         wd      <= '0;
         we      <= 1'b0;
         fe      <= 1'b0;
         ovr     <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_err <= 1'b0;
         pe      <= 1'b0;
`endif
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         bit_idx <= bit_nxt;
         wd      <= wd_nxt;
         we      <= we_nxt;
         fe      <= fe_nxt;
         ovr     <= ovr_nxt;
`ifdef UART_RX_PARITY_EN
         par_err <= par_err_nxt;
         pe      <= pe_nxt;
`endif
      end
   end

   // The shift register is pure data: its content is only consumed after a
   // full frame has overwritten it, so it needs no reset.
   always_ff @(posedge CLKip) begin
      shreg <= shreg_nxt;
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      bit_nxt   = bit_idx;
      shreg_nxt = shreg;
      wd_nxt    = wd;
      we_nxt    = 1'b0;
      fe_nxt    = 1'b0;
      ovr_nxt   = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_nxt = par_err;
      pe_nxt      = 1'b0;
`endif

      case (state)
         ST_IDLE: begin
            // Only a 1->0 edge arms the receiver, so a held-low line
            // (break) cannot start a stream of frames.
            if (rx_fall) begin
               state_nxt = ST_START;
               cnt_nxt   = CNT_HALF;
            end
         end

         ST_START: begin
            if (!cnt_zero) begin
               cnt_nxt = cnt - CNT_W'(1);
            end else if (!rx_sync) begin
               state_nxt = ST_DATA;
               cnt_nxt   = CNT_FULL;
               bit_nxt   = '0;
`ifdef UART_RX_PARITY_EN
               par_err_nxt = 1'b0;
`endif
            end else begin
               // Line back high at mid-start: a glitch, dropped silently.
               state_nxt = ST_IDLE;
            end
         end

         ST_DATA: begin
            if (!cnt_zero) begin
               cnt_nxt = cnt - CNT_W'(1);
            end else begin
               shreg_nxt = {rx_sync, shreg[DATA_WIDTH-1:1]};
               cnt_nxt   = CNT_FULL;
               if (bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                  state_nxt = ST_PARITY;
`else
                  state_nxt = ST_STOP;
`endif
               end else begin
                  bit_nxt = bit_idx + BIT_W'(1);
               end
            end
         end

`ifdef UART_RX_PARITY_EN
         ST_PARITY: begin
            if (!cnt_zero) begin
               cnt_nxt = cnt - CNT_W'(1);
            end else begin
               // XOR over data plus parity bit is 0 for even, 1 for odd.
               par_err_nxt = ((^shreg) ^ rx_sync) != (PARITY_ODD != 0);
               cnt_nxt     = CNT_FULL;
               state_nxt   = ST_STOP;
            end
         end
`endif

         ST_STOP: begin
            if (!cnt_zero) begin
               cnt_nxt = cnt - CNT_W'(1);
            end else begin
               // Leave mid-stop-bit so a back-to-back start edge is caught.
               state_nxt = ST_IDLE;
               if (!rx_sync) begin
                  fe_nxt = 1'b1;
`ifdef UART_RX_PARITY_EN
               end else if (par_err) begin
                  pe_nxt = 1'b1;
`endif
               end else if (fifo.FULLi) begin
                  ovr_nxt = 1'b1;
               end else begin
                  we_nxt = 1'b1;
                  wd_nxt = shreg;
               end
            end
         end

         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   assign fifo.WEo = we;
   assign fifo.WDo = wd;
   assign FEo      = fe;
   assign OVRo     = ovr;
   assign BUSYo    = (state != ST_IDLE);
`ifdef UART_RX_PARITY_EN
   assign PEo      = pe;
`else
   assign PEo      = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx -- directed bench for uart_rx at 16 clocks per bit, 8 data bits.
module tb_uart_rx;

   localparam int CPB = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rxd = 1'b1;
   logic busy, fe, pe, ovr;

   int n_vec = 0;
   int n_err = 0;

   int we_cnt = 0, fe_cnt = 0, pe_cnt = 0, ovr_cnt = 0, multi_cnt = 0;
   logic [7:0] rx_q[$];

   int we0, fe0, pe0, ovr0;

   uart_rx_if #(.DATA_WIDTH(8)) fifo_if ();

   uart_rx #(
      .CLK_FREQ   (CPB * 115_200),
      .BAUD_RATE  (115_200),
      .DATA_WIDTH (8),
      .PARITY_ODD (0)
   ) dut (
      .CLKip (clk),
      .RSTi  (rst),
      .RXi   (rxd),
      .fifo  (fifo_if.master),
      .BUSYo (busy),
      .FEo   (fe),
      .PEo   (pe),
      .OVRo  (ovr)
   );

   always #5 clk = ~clk;

   // Pulse monitor: counts every result pulse and records written bytes.
   always @(negedge clk) begin
      if (fifo_if.WEo) begin
         we_cnt = we_cnt + 1;
         rx_q.push_back(fifo_if.WDo);
      end
      if (fe)  fe_cnt  = fe_cnt + 1;
      if (pe)  pe_cnt  = pe_cnt + 1;
      if (ovr) ovr_cnt = ovr_cnt + 1;
      if (int'(fifo_if.WEo) + int'(fe) + int'(pe) + int'(ovr) > 1)
         multi_cnt = multi_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic snap();
      we0 = we_cnt; fe0 = fe_cnt; pe0 = pe_cnt; ovr0 = ovr_cnt;
   endtask

   task automatic bit_time(input logic lvl);
      rxd = lvl;
      repeat (CPB) @(negedge clk);
   endtask

   // parbit < 0 means no parity bit on the wire.
   task automatic send(input logic [7:0] d, input logic stop, input int parbit);
      bit_time(1'b0);
      for (int i = 0; i < 8; i++) bit_time(d[i]);
      if (parbit >= 0) bit_time(parbit[0]);
      bit_time(stop);
   endtask

   task automatic idle(input int n);
      rxd = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   int par_arg;

   initial begin
`ifdef UART_RX_PARITY_EN
      par_arg = 0;
`else
      par_arg = -1;
`endif
      fifo_if.FULLi = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_we",   fifo_if.WEo, 0);
      chk("rst_wd",   fifo_if.WDo, 8'h00);
      chk("rst_busy", busy, 0);
      chk("rst_fe",   fe, 0);
      chk("rst_pe",   pe, 0);
      chk("rst_ovr",  ovr, 0);
      rst = 1'b0;
      idle(10);

      // Single frame 0xA5 (even parity bit for 0xA5 is 0)
      snap();
      bit_time(1'b0);
      chk("a5_busy_mid", busy, 1);
      for (int i = 0; i < 8; i++) bit_time(1'(8'hA5 >> i));
      if (par_arg >= 0) bit_time(1'b0);
      bit_time(1'b1);
      idle(5);
      chk("a5_we_cnt", we_cnt - we0, 1);
      chk("a5_data",   rx_q[rx_q.size()-1], 8'hA5);
      chk("a5_wdo",    fifo_if.WDo, 8'hA5);
      chk("a5_errs",   (fe_cnt - fe0) + (pe_cnt - pe0) + (ovr_cnt - ovr0), 0);
      chk("a5_busy",   busy, 0);

      // Back-to-back 0x00 then 0xFF (even parity bits 0, 0)
      snap();
      send(8'h00, 1'b1, par_arg);
      send(8'hFF, 1'b1, par_arg);
      idle(5);
      chk("b2b_we_cnt", we_cnt - we0, 2);
      chk("b2b_first",  rx_q[rx_q.size()-2], 8'h00);
      chk("b2b_second", rx_q[rx_q.size()-1], 8'hFF);

      // Short low glitch: rejected at mid-start
      snap();
      rxd = 1'b0;
      repeat (4) @(negedge clk);
      idle(10);
      chk("glitch_busy",   busy, 0);
      chk("glitch_pulses", (we_cnt - we0) + (fe_cnt - fe0) + (pe_cnt - pe0) + (ovr_cnt - ovr0), 0);

      // 0x3C with stop bit 0, then break for 100 bit times
      snap();
      send(8'h3C, 1'b0, par_arg);
      rxd = 1'b0;
      repeat (100 * CPB) @(negedge clk);
      chk("fe_cnt",    fe_cnt - fe0, 1);
      chk("fe_no_we",  we_cnt - we0, 0);
      chk("brk_busy",  busy, 0);
      idle(3 * CPB);
      chk("brk_after", (we_cnt - we0) + (fe_cnt - fe0) + (pe_cnt - pe0) + (ovr_cnt - ovr0), 1);

      // Overrun: 0x55 with FIFO full, then 0x66 with room
      snap();
      fifo_if.FULLi = 1'b1;
      send(8'h55, 1'b1, par_arg);
      idle(5);
      fifo_if.FULLi = 1'b0;
      chk("ovr_cnt",   ovr_cnt - ovr0, 1);
      chk("ovr_no_we", we_cnt - we0, 0);
      chk("ovr_wd_hold", fifo_if.WDo, 8'hFF);
      send(8'h66, 1'b1, par_arg);
      idle(5);
      chk("66_we_cnt", we_cnt - we0, 1);
      chk("66_wdo",    fifo_if.WDo, 8'h66);

      // Reset in the middle of the data bits
      snap();
      bit_time(1'b0);
      bit_time(1'b1);
      bit_time(1'b0);
      rst = 1'b1;
      #2;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_wd",   fifo_if.WDo, 8'h00);
      chk("mid_rst_we",   fifo_if.WEo, 0);
      rxd = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      idle(2 * CPB);
      chk("mid_rst_pulses", (we_cnt - we0) + (fe_cnt - fe0) + (pe_cnt - pe0) + (ovr_cnt - ovr0), 0);
      send(8'h81, 1'b1, par_arg);
      idle(5);
      chk("81_we_cnt", we_cnt - we0, 1);
      chk("81_wdo",    fifo_if.WDo, 8'h81);

`ifdef UART_RX_PARITY_EN
      // 0x07 has three ones: even parity bit must be 1
      snap();
      send(8'h07, 1'b1, 0);
      idle(5);
      chk("par_bad_pe", pe_cnt - pe0, 1);
      chk("par_bad_we", we_cnt - we0, 0);
      snap();
      send(8'h07, 1'b1, 1);
      idle(5);
      chk("par_ok_we", we_cnt - we0, 1);
      chk("par_ok_pe", pe_cnt - pe0, 0);
      chk("par_ok_wd", fifo_if.WDo, 8'h07);
`else
      chk("pe_never", pe_cnt, 0);
`endif

      chk("one_pulse_per_frame", multi_cnt, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
